// File: rtl/pe_job_sequencer.sv
// Per-PE job sequencer: takes one job descriptor, loads the PE filter FIFO, kicks the PE,
// then streams IF words in and drains output words out. Optional watchdog: PE_SEQ_WATCHDOG_EN.
module pe_job_sequencer #(
  parameter int FILT_ADDR_LEN = 4,
  parameter int IF_ADDR_LEN   = 4,
  parameter int FILT_DATA_W   = 8,
  parameter int IF_DATA_W     = 10,
  parameter int OUT_DATA_W    = 17,
  parameter int CNT_W         = 12,
  parameter int WDT_CYCLES    = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [CNT_W-1:0]         job_filt_words,
  input  logic [CNT_W-1:0]         job_if_words,
  input  logic [CNT_W-1:0]         job_out_words,
  input  logic [1:0]               job_mode,
  input  logic [FILT_ADDR_LEN-1:0] job_filt_len,
  input  logic [IF_ADDR_LEN-1:0]   job_stride_len,
  input  logic                     filt_src_valid,
  output logic                     filt_src_ready,
  input  logic [FILT_DATA_W-1:0]   filt_src_data,
  input  logic                     if_src_valid,
  output logic                     if_src_ready,
  input  logic [IF_DATA_W-1:0]     if_src_data,
  output logic                     sink_valid,
  input  logic                     sink_ready,
  output logic [OUT_DATA_W-1:0]    sink_data,
  output logic                     pe_filter_wen,
  output logic [FILT_DATA_W-1:0]   pe_filter_din,
  input  logic                     pe_filter_full,
  output logic                     pe_IF_wen,
  output logic [IF_DATA_W-1:0]     pe_IF_din,
  input  logic                     pe_IF_full,
  output logic                     pe_outbuf_ren,
  input  logic [OUT_DATA_W-1:0]    pe_outbuf_dout,
  input  logic                     pe_outbuf_empty,
  output logic                     pe_start,
  output logic [1:0]               pe_mode,
  output logic [FILT_ADDR_LEN-1:0] pe_filt_len,
  output logic [IF_ADDR_LEN-1:0]   pe_stride_len,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [2:0] {IDLE, LOAD_FILT, KICK, STREAM, DONE} state_t;

  if (WDT_CYCLES < 2) begin : g_wdt_range
    $error("WDT_CYCLES must be at least 2");
  end

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         filt_words_q, filt_words_d;
  logic [CNT_W-1:0]         if_words_q, if_words_d;
  logic [CNT_W-1:0]         out_words_q, out_words_d;
  logic [CNT_W-1:0]         f_cnt_q, f_cnt_d;
  logic [CNT_W-1:0]         i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0]         o_cnt_q, o_cnt_d;
  logic [1:0]               mode_q, mode_d;
  logic [FILT_ADDR_LEN-1:0] filt_len_q, filt_len_d;
  logic [IF_ADDR_LEN-1:0]   stride_q, stride_d;
  logic                     any_xfer;

`ifdef PE_SEQ_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             err_q, err_d;
`endif

  // Data paths are pure pass-through; only the strobes are gated by state.
  assign pe_filter_din = filt_src_data;
  assign pe_IF_din     = if_src_data;
  assign sink_data     = pe_outbuf_dout;
  assign pe_mode       = mode_q;
  assign pe_filt_len   = filt_len_q;
  assign pe_stride_len = stride_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

  always_comb begin
    state_d        = state_q;
    filt_words_d   = filt_words_q;
    if_words_d     = if_words_q;
    out_words_d    = out_words_q;
    f_cnt_d        = f_cnt_q;
    i_cnt_d        = i_cnt_q;
    o_cnt_d        = o_cnt_q;
    mode_d         = mode_q;
    filt_len_d     = filt_len_q;
    stride_d       = stride_q;
    job_ready      = 1'b0;
    filt_src_ready = 1'b0;
    if_src_ready   = 1'b0;
    sink_valid     = 1'b0;
    pe_filter_wen  = 1'b0;
    pe_IF_wen      = 1'b0;
    pe_outbuf_ren  = 1'b0;
    pe_start       = 1'b0;
    any_xfer       = 1'b0;
`ifdef PE_SEQ_WATCHDOG_EN
    err_d          = err_q;
    wdt_d          = '0;
`endif

    case (state_q)
      IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          filt_words_d = job_filt_words;
          if_words_d   = job_if_words;
          out_words_d  = job_out_words;
          mode_d       = job_mode;
          filt_len_d   = job_filt_len;
          stride_d     = job_stride_len;
          f_cnt_d      = '0;
          i_cnt_d      = '0;
          o_cnt_d      = '0;
`ifdef PE_SEQ_WATCHDOG_EN
          err_d        = 1'b0;
`endif
          state_d      = (job_filt_words != '0) ? LOAD_FILT : KICK;
        end
      end

      LOAD_FILT: begin
        filt_src_ready = ~pe_filter_full & (f_cnt_q < filt_words_q);
        pe_filter_wen  = filt_src_valid & filt_src_ready;
        if (pe_filter_wen) begin
          any_xfer = 1'b1;
          f_cnt_d  = f_cnt_q + 1'b1;
          if (f_cnt_d == filt_words_q) state_d = KICK;
        end
      end

      KICK: begin
        pe_start = 1'b1;
        state_d  = (if_words_q == '0 && out_words_q == '0) ? DONE : STREAM;
      end

      STREAM: begin
        if_src_ready  = ~pe_IF_full & (i_cnt_q < if_words_q);
        pe_IF_wen     = if_src_valid & if_src_ready;
        sink_valid    = ~pe_outbuf_empty & (o_cnt_q < out_words_q);
        pe_outbuf_ren = sink_valid & sink_ready;
        any_xfer      = pe_IF_wen | pe_outbuf_ren;
        if (pe_IF_wen)     i_cnt_d = i_cnt_q + 1'b1;
        if (pe_outbuf_ren) o_cnt_d = o_cnt_q + 1'b1;
        // Leave as soon as the final transfer lands so DONE follows it directly.
        if (i_cnt_d == if_words_q && o_cnt_d == out_words_q) state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef PE_SEQ_WATCHDOG_EN
    // Stall timer only advances while a data phase is waiting with nothing moving.
    if ((state_q == LOAD_FILT || state_q == STREAM) && state_d == state_q && !any_xfer) begin
      wdt_d = wdt_q + 1'b1;
      if (wdt_d == WDT_W'(WDT_CYCLES)) begin
        wdt_d   = '0;
        err_d   = 1'b1;
        state_d = DONE;
      end
    end
`endif
  end

`ifdef PE_SEQ_WATCHDOG_EN
  assign err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_q <= '0;
      err_q <= 1'b0;
    end else begin
      wdt_q <= wdt_d;
      err_q <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      filt_words_q <= '0;
      if_words_q   <= '0;
      out_words_q  <= '0;
      f_cnt_q      <= '0;
      i_cnt_q      <= '0;
      o_cnt_q      <= '0;
      mode_q       <= '0;
      filt_len_q   <= '0;
      stride_q     <= '0;
    end else begin
      state_q      <= state_d;
      filt_words_q <= filt_words_d;
      if_words_q   <= if_words_d;
      out_words_q  <= out_words_d;
      f_cnt_q      <= f_cnt_d;
      i_cnt_q      <= i_cnt_d;
      o_cnt_q      <= o_cnt_d;
      mode_q       <= mode_d;
      filt_len_q   <= filt_len_d;
      stride_q     <= stride_d;
    end
  end

endmodule

// File: tb/tb_pe_job_sequencer.sv
// Directed bench for pe_job_sequencer: the PE and the streams are modelled by counters here.
module tb_pe_job_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready;
  logic [11:0] job_filt_words, job_if_words, job_out_words;
  logic [1:0]  job_mode;
  logic [3:0]  job_filt_len, job_stride_len;
  logic        filt_src_valid, filt_src_ready;
  logic [7:0]  filt_src_data;
  logic        if_src_valid, if_src_ready;
  logic [9:0]  if_src_data;
  logic        sink_valid, sink_ready;
  logic [16:0] sink_data;
  logic        pe_filter_wen, pe_filter_full;
  logic [7:0]  pe_filter_din;
  logic        pe_IF_wen, pe_IF_full;
  logic [9:0]  pe_IF_din;
  logic        pe_outbuf_ren, pe_outbuf_empty;
  logic [16:0] pe_outbuf_dout;
  logic        pe_start, busy, done, err;
  logic [1:0]  pe_mode;
  logic [3:0]  pe_filt_len, pe_stride_len;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          n_filt, n_if, n_pop, n_start, n_done;
  int          acc_cyc, start_cyc, done_cyc, ob_loaded;
  int          filt_cyc [8];
  logic [7:0]  filt_dat [8];
  logic [16:0] last_sink;
  logic        clr;
  bit          seen;
  int          stall_wen;

  always #5 clk = ~clk;

  pe_job_sequencer dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_filt_words(job_filt_words), .job_if_words(job_if_words), .job_out_words(job_out_words),
    .job_mode(job_mode), .job_filt_len(job_filt_len), .job_stride_len(job_stride_len),
    .filt_src_valid(filt_src_valid), .filt_src_ready(filt_src_ready), .filt_src_data(filt_src_data),
    .if_src_valid(if_src_valid), .if_src_ready(if_src_ready), .if_src_data(if_src_data),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_data(sink_data),
    .pe_filter_wen(pe_filter_wen), .pe_filter_din(pe_filter_din), .pe_filter_full(pe_filter_full),
    .pe_IF_wen(pe_IF_wen), .pe_IF_din(pe_IF_din), .pe_IF_full(pe_IF_full),
    .pe_outbuf_ren(pe_outbuf_ren), .pe_outbuf_dout(pe_outbuf_dout), .pe_outbuf_empty(pe_outbuf_empty),
    .pe_start(pe_start), .pe_mode(pe_mode), .pe_filt_len(pe_filt_len), .pe_stride_len(pe_stride_len),
    .busy(busy), .done(done), .err(err)
  );

  // Sources hand out sequential words; the output buffer holds ob_loaded words.
  assign filt_src_data   = 8'hA0 + 8'(n_filt);
  assign if_src_data     = 10'h040 + 10'(n_if);
  assign pe_outbuf_empty = (n_pop >= ob_loaded);
  assign pe_outbuf_dout  = 17'h100 + 17'(n_pop);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      n_filt <= 0; n_if <= 0; n_pop <= 0; n_start <= 0; n_done <= 0;
      acc_cyc <= -1; start_cyc <= -1; done_cyc <= -1; last_sink <= '0;
    end else begin
      if (job_valid && job_ready) acc_cyc <= cyc;
      if (pe_filter_wen) begin
        if (n_filt < 8) begin
          filt_cyc[n_filt] <= cyc;
          filt_dat[n_filt] <= pe_filter_din;
        end
        n_filt <= n_filt + 1;
      end
      if (pe_IF_wen) n_if <= n_if + 1;
      if (pe_outbuf_ren) begin
        n_pop     <= n_pop + 1;
        last_sink <= sink_data;
      end
      if (pe_start) begin n_start <= n_start + 1; start_cyc <= cyc; end
      if (done)     begin n_done  <= n_done + 1;  done_cyc  <= cyc; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic prep(input int loaded);
    @(negedge clk);
    clr = 1'b1;
    ob_loaded = loaded;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic submit(input logic [11:0] f, input logic [11:0] i, input logic [11:0] o,
                        input logic [1:0] m, input logic [3:0] fl, input logic [3:0] sl);
    @(negedge clk);
    job_valid = 1'b1;
    job_filt_words = f; job_if_words = i; job_out_words = o;
    job_mode = m; job_filt_len = fl; job_stride_len = sl;
    #1 chk("job_ready_at_accept", {31'd0, job_ready}, 32'd1);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit found);
    found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        found = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_job(input string tag);
    wait_done(200, seen);
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      chk({tag, "_ready_after"}, {31'd0, job_ready}, 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b1; ob_loaded = 0;
    job_valid = 1'b0; job_filt_words = '0; job_if_words = '0; job_out_words = '0;
    job_mode = '0; job_filt_len = '0; job_stride_len = '0;
    filt_src_valid = 1'b1; if_src_valid = 1'b1; sink_ready = 1'b1;
    pe_filter_full = 1'b0; pe_IF_full = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_job_ready", {31'd0, job_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_start", {31'd0, pe_start}, 32'd0);
    chk("rst_filt_ready", {31'd0, filt_src_ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    // Reset while streaming aborts without a done pulse.
    prep(0);
    submit(12'd4, 12'd16, 12'd8, 2'd2, 4'd5, 4'd3);
    for (int k = 0; k < 100 && n_if < 5; k++) @(negedge clk);
    chk("midrst_if_reached", n_if, 32'd5);
    chk("midrst_mode_before", {30'd0, pe_mode}, 32'd2);
    rst = 1'b1;
    #1;
    chk("midrst_job_ready", {31'd0, job_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_mode", {30'd0, pe_mode}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_no_done", n_done, 32'd0);

    // Nominal job with everything ready and outputs waiting.
    prep(4);
    submit(12'd3, 12'd6, 12'd4, 2'd1, 4'd3, 4'd2);
    finish_job("nom");
    chk("nom_filt_cnt", n_filt, 32'd3);
    chk("nom_first_filt_lat", filt_cyc[0], acc_cyc + 1);
    chk("nom_filt_back2back", filt_cyc[2], filt_cyc[0] + 2);
    chk("nom_start_lat", start_cyc, filt_cyc[2] + 1);
    chk("nom_start_cnt", n_start, 32'd1);
    chk("nom_if_cnt", n_if, 32'd6);
    chk("nom_pop_cnt", n_pop, 32'd4);
    chk("nom_done_cnt", n_done, 32'd1);
    chk("nom_filt_d0", {24'd0, filt_dat[0]}, 32'hA0);
    chk("nom_filt_d2", {24'd0, filt_dat[2]}, 32'hA2);
    chk("nom_last_sink", {15'd0, last_sink}, 32'h103);
    chk("nom_mode_hold", {30'd0, pe_mode}, 32'd1);
    chk("nom_flen_hold", {28'd0, pe_filt_len}, 32'd3);
    chk("nom_stride_hold", {28'd0, pe_stride_len}, 32'd2);

    // Filter FIFO full for five cycles after the first word.
    prep(4);
    submit(12'd3, 12'd6, 12'd4, 2'd1, 4'd3, 4'd2);
    for (int k = 0; k < 50 && n_filt < 1; k++) @(negedge clk);
    pe_filter_full = 1'b1;
    stall_wen = 0;
    for (int k = 0; k < 5; k++) begin
      #1 if (pe_filter_wen || filt_src_ready) stall_wen++;
      @(negedge clk);
    end
    chk("stall_no_wen", stall_wen, 32'd0);
    chk("stall_cnt_held", n_filt, 32'd1);
    pe_filter_full = 1'b0;
    finish_job("stall");
    chk("stall_filt_cnt", n_filt, 32'd3);
    chk("stall_d1", {24'd0, filt_dat[1]}, 32'hA1);
    chk("stall_d2", {24'd0, filt_dat[2]}, 32'hA2);
    chk("stall_gap", filt_cyc[1], filt_cyc[0] + 6);

    // Empty job goes straight through KICK to DONE.
    prep(0);
    submit(12'd0, 12'd0, 12'd0, 2'd3, 4'd1, 4'd1);
    chk("zero_start_now", {31'd0, pe_start}, 32'd1);
    finish_job("zero");
    chk("zero_start_lat", start_cyc, acc_cyc + 1);
    chk("zero_done_lat", done_cyc, acc_cyc + 2);
    chk("zero_filt_cnt", n_filt, 32'd0);

    // Sink backpressure, and a buffer holding more words than the job drains.
    prep(10);
    sink_ready = 1'b0;
    submit(12'd0, 12'd0, 12'd8, 2'd0, 4'd0, 4'd0);
    @(negedge clk);
    #1;
    chk("bp_valid", {31'd0, sink_valid}, 32'd1);
    chk("bp_data", {15'd0, sink_data}, 32'h100);
    chk("bp_no_ren", {31'd0, pe_outbuf_ren}, 32'd0);
    @(negedge clk);
    #1;
    chk("bp_valid_held", {31'd0, sink_valid}, 32'd1);
    chk("bp_data_stable", {15'd0, sink_data}, 32'h100);
    chk("bp_no_pop", n_pop, 32'd0);
    sink_ready = 1'b1;
    finish_job("drain");
    chk("drain_pops", n_pop, 32'd8);
    chk("drain_last", {15'd0, last_sink}, 32'h107);
    chk("drain_left", {31'd0, pe_outbuf_empty}, 32'd0);

    // IF source stalls forever: no watchdog in this build, so the job just waits.
    prep(0);
    if_src_valid = 1'b0;
    submit(12'd0, 12'd2, 12'd0, 2'd1, 4'd2, 4'd2);
    repeat (40) @(negedge clk);
    chk("hang_err", {31'd0, err}, 32'd0);
    chk("hang_busy", {31'd0, busy}, 32'd1);
    chk("hang_if_ready", {31'd0, if_src_ready}, 32'd1);
    chk("hang_no_done", n_done, 32'd0);
    if_src_valid = 1'b1;
    finish_job("hang");
    chk("hang_if_cnt", n_if, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
